// File: rtl/modq_pkg.sv
// Shared constants and types for the Kyber mod-q multiply arbiter.
package modq_pkg;
    localparam int Q      = 3329;
    localparam int COEF_W = 12;
    localparam int PROD_W = 24;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic              tag_t;
endpackage

// File: rtl/modq_mul_arbiter_if.sv
// Request/response bundle between the two requesters and the shared multiplier.
interface modq_mul_arbiter_if;
    import modq_pkg::*;

    logic        [1:0] req_valid;
    logic        [1:0] req_ready;
    coef_t       [1:0] req_a;
    coef_t       [1:0] req_b;
    logic        [1:0] rsp_valid;
    logic        [1:0] rsp_ready;
    coef_t       [1:0] rsp_data;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mod_reduce_3329.sv
// Combinational Barrett reduction of a 24-bit value to [0, Q).
module mod_reduce_3329
    import modq_pkg::*;
(
    input  prod_t x,
    output coef_t r
);
    // floor(2^24 / Q); the quotient estimate is at most one short, so one
    // conditional subtract finishes the job for every 24-bit input.
    localparam int unsigned BARRETT_M = 5039;

    logic [12:0] q_est;
    logic [12:0] rem;

    assign q_est = 13'(({13'd0, x} * 37'(BARRETT_M)) >> PROD_W);
    assign rem   = 13'(x - prod_t'(q_est) * prod_t'(Q));
    assign r     = (rem >= 13'(Q)) ? coef_t'(rem - 13'(Q)) : rem[COEF_W-1:0];
endmodule

// File: rtl/modq_mul_arbiter.sv
// Round-robin shared 12x12 multiply + mod-Q pipeline with credit-guarded
// per-requester response FIFOs.
module modq_mul_arbiter
    import modq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NREQ       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    modq_mul_arbiter_if.slave    bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 2;
    localparam int STAGES = 2;

    logic [STAGES-1:0]            vld_pipe;
    tag_t [STAGES-1:0]            tag_pipe;
    prod_t                        s1_prod;
    coef_t                        s1_red;
    coef_t                        s2_res;
    logic                         prio;
    tag_t                         sel;
    logic [NREQ-1:0]              elig;
    logic [NREQ-1:0]              grant;
    logic [NREQ-1:0]              push;
    logic [NREQ-1:0]              pop;
    logic [NREQ-1:0]              nonempty;
    logic [NREQ-1:0][CNT_W-1:0]   used;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W:0]   count;
        logic [1:0]       inflight;
        coef_t            mem [FIFO_DEPTH];

        assign inflight = 2'(vld_pipe[0] && (tag_pipe[0] == tag_t'(g)))
                        + 2'(vld_pipe[1] && (tag_pipe[1] == tag_t'(g)));
        // Credits cover both queued and still-in-flight results, so a push
        // can never land on a full FIFO.
        assign used[g]     = CNT_W'(count) + CNT_W'(inflight);
        assign elig[g]     = bus.req_valid[g] && (used[g] < CNT_W'(FIFO_DEPTH));
        assign push[g]     = vld_pipe[1] && (tag_pipe[1] == tag_t'(g));
        assign nonempty[g] = (count != '0);
        assign pop[g]      = nonempty[g] && bus.rsp_ready[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[g], pop[g]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr] <= s2_res;
        end

        assign bus.rsp_valid[g] = nonempty[g];
        assign bus.rsp_data[g]  = nonempty[g] ? mem[rd_ptr] : '0;
    end

    // Tie goes to the requester not served last; prio holds that index.
    always_comb begin
        grant = '0;
        if (&elig) grant[prio] = 1'b1;
        else       grant = elig;
    end

    assign bus.req_ready = grant & {NREQ{rst_n}};
    assign sel           = tag_t'(grant[1]);

    mod_reduce_3329 u_reduce (
        .x (s1_prod),
        .r (s1_red)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            s1_prod  <= '0;
            s2_res   <= '0;
            prio     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], |bus.req_ready};
            tag_pipe <= {tag_pipe[0], sel};
            s2_res   <= s1_red;
            if (|bus.req_ready) begin
                s1_prod <= prod_t'(bus.req_a[sel]) * prod_t'(bus.req_b[sel]);
                prio    <= ~sel;
            end
        end
    end

    assign bus.busy = (|vld_pipe) | (|nonempty);
endmodule

// File: tb/tb_modq_mul_arbiter.sv
// Self-checking bench: directed vectors plus randomized traffic against a
// queue-based reference model of credits, round-robin and 3-cycle latency.
module tb_modq_mul_arbiter;
    import modq_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    modq_mul_arbiter_if ifc ();

    modq_mul_arbiter #(.FIFO_DEPTH(DEPTH), .NREQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-requester outstanding counts and result queues.
    typedef struct {
        int     val;
        longint due;
    } ent_t;

    ent_t       mq[2][$];
    int         outst[2];
    int         prefer = 0;
    longint     cyc    = 0;
    logic [1:0] glog[$];

    always @(negedge clk) begin
        logic [1:0] el;
        logic [1:0] eg;
        logic [1:0] ev;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", int'(ifc.req_ready), 0);
            chk("rst_rsp_valid", int'(ifc.rsp_valid), 0);
            chk("rst_rsp_data",  int'(ifc.rsp_data), 0);
            chk("rst_busy",      int'(ifc.busy), 0);
            mq[0].delete();
            mq[1].delete();
            outst[0] = 0;
            outst[1] = 0;
            prefer   = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                el[i] = ifc.req_valid[i] && (outst[i] < DEPTH);
                ev[i] = (mq[i].size() > 0) && (mq[i][0].due <= cyc);
            end
            if (el == 2'b11) eg = (prefer == 1) ? 2'b10 : 2'b01;
            else             eg = el;
            chk("grant",     int'(ifc.req_ready), int'(eg));
            chk("rsp_valid", int'(ifc.rsp_valid), int'(ev));
            for (int i = 0; i < 2; i++)
                if (ev[i]) chk("rsp_data", int'(ifc.rsp_data[i]), mq[i][0].val);
            chk("busy", int'(ifc.busy), int'((outst[0] + outst[1]) > 0));
            glog.push_back(ifc.req_ready);
            for (int i = 0; i < 2; i++) begin
                if (ev[i] && ifc.rsp_ready[i]) begin
                    void'(mq[i].pop_front());
                    outst[i]--;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (eg[i]) begin
                    mq[i].push_back('{(int'(ifc.req_a[i]) * int'(ifc.req_b[i])) % Q, cyc + 3});
                    outst[i]++;
                    prefer = 1 - i;
                end
            end
        end
    end

    function automatic coef_t rand_coef();
        case ($urandom_range(5, 0))
            0:       return coef_t'(0);
            1:       return coef_t'(4095);
            2:       return coef_t'(Q - 1);
            3:       return coef_t'(Q);
            default: return coef_t'($urandom_range(4095, 0));
        endcase
    endfunction

    // Holds each request until accepted; called and returns at posedge+1.
    task automatic drive(input int n, input logic [1:0] vm, input logic [1:0] rr, input bit rnd);
        logic [1:0] acc;
        logic [1:0] pend;
        pend = 2'b00;
        glog.delete();
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && vm[i] && (!rnd || $urandom_range(1, 0) == 1)) begin
                    pend[i] = 1'b1;
                    ifc.req_a[i] = rand_coef();
                    ifc.req_b[i] = rand_coef();
                end
            end
            ifc.req_valid = pend;
            ifc.rsp_ready = rnd ? 2'($urandom_range(3, 0)) : rr;
            @(negedge clk);
            acc = ifc.req_ready & ifc.req_valid;
            @(posedge clk);
            #1;
            pend = pend & ~acc;
        end
        ifc.req_valid = 2'b00;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b11;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = !ifc.busy;
        end
        chk("idle_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    function automatic int count0(input int from);
        int n;
        n = 0;
        for (int k = from; k < glog.size(); k++) n += int'(glog[k][0]);
        return n;
    endfunction

    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit ok;
        int n0;

        vt[0] = '{1234, 2345, 829};
        vt[1] = '{3328, 3328, 1};
        vt[2] = '{2, 1665, 1};
        vt[3] = '{0, 4095, 0};
        vt[4] = '{4095, 4095, 852};
        vt[5] = '{17, 17, 289};

        ifc.req_valid = 2'b00;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.rsp_ready = 2'b00;

        #2 rst_n = 1'b0;
        #1;
        chk("init_req_ready", int'(ifc.req_ready), 0);
        chk("init_rsp_valid", int'(ifc.rsp_valid), 0);
        chk("init_busy",      int'(ifc.busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors on requester 0 with exact latency check.
        ifc.rsp_ready = 2'b11;
        foreach (vt[v]) begin
            ifc.req_a[0]  = coef_t'(vt[v].a);
            ifc.req_b[0]  = coef_t'(vt[v].b);
            ifc.req_valid = 2'b01;
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                ok = ifc.req_ready[0];
            end
            chk("vec_accept", int'(ok), 1);
            @(posedge clk);
            #1 ifc.req_valid = 2'b00;
            repeat (2) @(negedge clk);
            chk("vec_early_valid", int'(ifc.rsp_valid[0]), 0);
            @(negedge clk);
            chk("vec_valid", int'(ifc.rsp_valid[0]), 1);
            chk("vec_data",  int'(ifc.rsp_data[0]), vt[v].exp);
            chk("vec_rsp1",  int'(ifc.rsp_valid[1]), 0);
            @(posedge clk);
            #1;
        end

        // Both streaming, both draining: strict alternation.
        wait_idle();
        drive(16, 2'b11, 2'b11, 1'b0);
        for (int k = 1; k < glog.size(); k++) begin
            chk("alt_onehot", $countones(glog[k]), 1);
            chk("alt_switch", int'(glog[k] != glog[k-1]), 1);
        end

        // Requester 0 backpressured: four credits then stalled.
        wait_idle();
        drive(20, 2'b11, 2'b10, 1'b0);
        chk("bp_r0_count", count0(0), DEPTH);
        for (int k = 10; k < 20; k++) chk("bp_r1_only", int'(glog[k]), 2);
        drive(20, 2'b11, 2'b11, 1'b0);
        chk("bp_resume", int'(count0(0) > 0), 1);

        // Full FIFO then steady push/pop on requester 0.
        wait_idle();
        drive(8, 2'b01, 2'b00, 1'b0);
        chk("fill_count", count0(0), DEPTH);
        drive(30, 2'b01, 2'b01, 1'b0);
        n0 = count0(0);
        chk("stream_rate", int'(n0 >= 25), 1);

        // Random traffic and consumer stalls.
        wait_idle();
        drive(400, 2'b11, 2'b00, 1'b1);

        // Async reset with work queued and in flight.
        wait_idle();
        ifc.rsp_ready = 2'b00;
        ifc.req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            ifc.req_a[0] = rand_coef();
            ifc.req_b[0] = rand_coef();
            @(posedge clk);
            #1;
        end
        ifc.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 ifc.req_valid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            ifc.req_a[1] = rand_coef();
            ifc.req_b[1] = rand_coef();
            @(posedge clk);
            #1;
        end
        ifc.req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", int'(ifc.req_ready), 0);
        chk("arst_rsp_valid", int'(ifc.rsp_valid), 0);
        chk("arst_rsp_data",  int'(ifc.rsp_data), 0);
        chk("arst_busy",      int'(ifc.busy), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        ifc.rsp_ready = 2'b11;
        @(negedge clk);
        chk("arst_rr_first", int'(ifc.req_ready), 1);
        @(posedge clk);
        #1 ifc.req_valid = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("arst_no_stale1", int'(ifc.rsp_valid[1]), 0);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
